// File: rtl/cai_submit_arbiter.sv
// Round-robin arbiter sharing one CAI submit port among N_REQ doorbell-counting requesters.
// Latency: doorbell at t -> grant decision at t+1 -> cai_submit_doorbell pulse at t+2; one descriptor in flight.
// Backpressure: doorbells queue in saturating per-requester counters (sticky overflow); optional watchdog under CAI_ARB_TIMEOUT_EN.
module cai_submit_arbiter #(
    parameter int N_REQ       = 4,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_doorbell,
    input  logic [N_REQ*64-1:0]   req_desc_base,
    input  logic [N_REQ*32-1:0]   req_ring_mask,
    input  logic [N_REQ*16-1:0]   req_context,
    output logic [N_REQ-1:0]      req_done,
    output logic [N_REQ-1:0]      req_overflow,
    output logic [63:0]           cai_submit_desc_base,
    output logic [31:0]           cai_submit_ring_mask,
    output logic [15:0]           cai_context_sel,
    output logic                  cai_submit_doorbell,
    input  logic                  cai_comp_doorbell,
    output logic                  busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                  timeout
);

    localparam int GW = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_COMP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt [N_REQ];
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     rr_next;
    logic              found;
    logic [GW-1:0]     winner;
    logic [GW:0]       scan_sum;
    logic [GW-1:0]     scan_idx;
    logic              grant_fire;
    logic [N_REQ-1:0]  dec_vec;
    logic              comp_seen;
    logic              expire;

    // Round-robin search: first requester with pending work, starting at rr_ptr.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
            if (scan_sum >= (GW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (GW+1)'(N_REQ);
            end
            scan_idx = scan_sum[GW-1:0];
            if (!found && (cnt[scan_idx] != '0)) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign grant_fire = (state == IDLE) && found;
    assign comp_seen  = (state == WAIT_COMP) && cai_comp_doorbell;

    // Decrement strobe for the requester granted this cycle.
    always_comb begin
        dec_vec = '0;
        if (grant_fire) begin
            dec_vec[winner] = 1'b1;
        end
    end

    // Pointer that moves past the current winner, wrapping at N_REQ.
    always_comb begin
        rr_next = grant_id + 1'b1;
        if (grant_id == GW'(N_REQ - 1)) begin
            rr_next = '0;
        end
    end

`ifdef CAI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Watchdog: counts WAIT_COMP cycles; cleared while in GRANT so it starts at 0 on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == GRANT) begin
            wd_cnt <= '0;
        end else if (state == WAIT_COMP) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A completion arriving in the expiry cycle takes priority over the abort.
    assign expire = (state == WAIT_COMP) && !cai_comp_doorbell &&
                    (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Registered one-cycle abort pulse, aligned with the return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state logic for the grant FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = WAIT_COMP;
            end
            WAIT_COMP: begin
                if (cai_comp_doorbell || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, grant latch, CAI port registers, completion pulse and RR pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            grant_id             <= '0;
            cai_submit_desc_base <= '0;
            cai_submit_ring_mask <= '0;
            cai_context_sel      <= '0;
            req_done             <= '0;
        end else begin
            state    <= state_nxt;
            req_done <= '0;
            if (grant_fire) begin
                grant_id             <= winner;
                cai_submit_desc_base <= req_desc_base[int'(winner)*64 +: 64];
                cai_submit_ring_mask <= req_ring_mask[int'(winner)*32 +: 32];
                cai_context_sel      <= req_context[int'(winner)*16 +: 16];
            end
            if (comp_seen) begin
                req_done[grant_id] <= 1'b1;
                rr_ptr             <= rr_next;
            end else if (expire) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // Per-requester pending counters: saturate at max and flag overflow stickily.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
            req_overflow <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_doorbell[i] && !dec_vec[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        req_overflow[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (dec_vec[i] && !req_doorbell[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign busy                = (state != IDLE);
    assign cai_submit_doorbell = (state == GRANT);

endmodule

// File: tb/tb_cai_submit_arbiter.sv
// Self-checking bench for cai_submit_arbiter: directed scenarios plus a per-cycle reference model.
// Latency: model outputs are compared on every falling edge after reset.
// Backpressure: a bench responder returns completions after a fixed delay unless held.
module tb_cai_submit_arbiter;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int TO   = 64;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_doorbell;
    logic [N*64-1:0] req_desc_base;
    logic [N*32-1:0] req_ring_mask;
    logic [N*16-1:0] req_context;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_overflow;
    logic [63:0]     cai_submit_desc_base;
    logic [31:0]     cai_submit_ring_mask;
    logic [15:0]     cai_context_sel;
    logic            cai_submit_doorbell;
    logic            cai_comp_doorbell;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout;

    cai_submit_arbiter #(.N_REQ(N), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_doorbell         (req_doorbell),
        .req_desc_base        (req_desc_base),
        .req_ring_mask        (req_ring_mask),
        .req_context          (req_context),
        .req_done             (req_done),
        .req_overflow         (req_overflow),
        .cai_submit_desc_base (cai_submit_desc_base),
        .cai_submit_ring_mask (cai_submit_ring_mask),
        .cai_context_sel      (cai_context_sel),
        .cai_submit_doorbell  (cai_submit_doorbell),
        .cai_comp_doorbell    (cai_comp_doorbell),
        .busy                 (busy),
        .grant_id             (grant_id),
        .timeout              (timeout)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (spec rules, integer arithmetic) ----------------
    int          m_pend [N];
    logic [N-1:0] m_ovf;
    int          m_rr;
    int          m_phase;     // 0 idle, 1 submit cycle, 2 awaiting completion
    int          m_gid;
    int          m_wait;
    int          mw;
    logic [63:0] m_base;
    logic [31:0] m_mask;
    logic [15:0] m_ctx;
    logic [N-1:0] m_done;
    logic        m_to;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_ovf = '0; m_rr = 0; m_phase = 0; m_gid = 0; m_wait = 0;
            m_base = '0; m_mask = '0; m_ctx = '0; m_done = '0; m_to = 1'b0;
        end else begin
            m_done = '0;
            m_to   = 1'b0;
            mw     = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (mw < 0 && m_pend[(m_rr + k) % N] > 0) mw = (m_rr + k) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_doorbell[i] && mw != i) begin
                    if (m_pend[i] == MAXC) m_ovf[i] = 1'b1;
                    else m_pend[i] = m_pend[i] + 1;
                end else if (!req_doorbell[i] && mw == i) begin
                    m_pend[i] = m_pend[i] - 1;
                end
            end
            if (m_phase == 0) begin
                if (mw >= 0) begin
                    m_gid  = mw;
                    m_base = req_desc_base[mw*64 +: 64];
                    m_mask = req_ring_mask[mw*32 +: 32];
                    m_ctx  = req_context[mw*16 +: 16];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_wait  = 0;
            end else begin
                if (cai_comp_doorbell) begin
                    m_done[m_gid] = 1'b1;
                    m_rr    = (m_gid + 1) % N;
                    m_phase = 0;
                end else begin
                    m_wait = m_wait + 1;
`ifdef CAI_ARB_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_to    = 1'b1;
                        m_rr    = (m_gid + 1) % N;
                        m_phase = 0;
                    end
`endif
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_phase != 0));
            check("submit_doorbell", 64'(cai_submit_doorbell), 64'(m_phase == 1));
            check("grant_id", 64'(grant_id), 64'(m_gid));
            check("desc_base", cai_submit_desc_base, m_base);
            check("ring_mask", 64'(cai_submit_ring_mask), 64'(m_mask));
            check("context_sel", 64'(cai_context_sel), 64'(m_ctx));
            check("req_done", 64'(req_done), 64'(m_done));
            check("req_overflow", 64'(req_overflow), 64'(m_ovf));
            check("timeout", 64'(timeout), 64'(m_to));
        end
    end

    // ---------------- monitor: grant log and per-requester tallies ----------------
    int grant_log [$];
    int sub_cnt  [N];
    int done_cnt [N];
    int to_cnt = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            sub_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (cai_submit_doorbell) begin
                grant_log.push_back(int'(grant_id));
                sub_cnt[grant_id] = sub_cnt[grant_id] + 1;
            end
            for (int i = 0; i < N; i++) begin
                if (req_done[i]) done_cnt[i] = done_cnt[i] + 1;
            end
            if (timeout) to_cnt = to_cnt + 1;
        end
    end

    // ---------------- accelerator responder ----------------
    bit comp_hold  = 1'b0;
    bit stray_comp = 1'b0;
    int comp_wait  = 0;

    always @(negedge clk) begin
        cai_comp_doorbell = stray_comp;
        if (rst) begin
            comp_wait = 0;
        end else if (cai_submit_doorbell) begin
            comp_wait = 3;
        end else if (comp_wait > 0 && !comp_hold) begin
            comp_wait = comp_wait - 1;
            if (comp_wait == 0) cai_comp_doorbell = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    int s_sub  [N];
    int s_done [N];

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            s_sub[i]  = sub_cnt[i];
            s_done[i] = done_cnt[i];
        end
    endtask

    task automatic db(input logic [N-1:0] v, input int n);
        @(negedge clk);
        req_doorbell = v;
        repeat (n) @(negedge clk);
        req_doorbell = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int run;
        int n;
        run = 0;
        n   = 0;
        while (run < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (busy) run = 0;
            else run++;
        end
        check(name, 64'(run >= 3), 64'd1);
    endtask

    int exp_ord [6];
    int log_base;
    int n;
    bit seen;

    initial begin
        rst          = 1'b1;
        req_doorbell = '0;
        for (int i = 0; i < N; i++) begin
            req_desc_base[i*64 +: 64] = 64'h1000 * (i + 1);
            req_ring_mask[i*32 +: 32] = 32'h0f + i;
            req_context[i*16 +: 16]   = 16'h00a0 + i;
        end
        req_desc_base[63:0] = 64'h100;
        req_ring_mask[31:0] = 32'd7;
        req_context[15:0]   = 16'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_base", cai_submit_desc_base, 64'd0);

        // Single request: submit two cycles after the doorbell
        snap();
        db(4'b0001, 1);
        check("single_t1_no_submit", 64'(cai_submit_doorbell), 64'd0);
        @(negedge clk);
        check("single_t2_submit", 64'(cai_submit_doorbell), 64'd1);
        check("single_base", cai_submit_desc_base, 64'h100);
        check("single_mask", 64'(cai_submit_ring_mask), 64'd7);
        wait_quiet("single_quiet");
        check("single_done", 64'(done_cnt[0] - s_done[0]), 64'd1);

        // Stray completion in IDLE must be ignored
        snap();
        stray_comp = 1'b1;
        repeat (2) @(negedge clk);
        stray_comp = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_no_done", 64'(done_cnt[0] - s_done[0]), 64'd0);
        check("stray_idle", 64'(busy), 64'd0);

        // Fairness: three requesters, two doorbells each
        do_reset();
        snap();
        log_base = grant_log.size();
        db(4'b0111, 2);
        wait_quiet("fair_quiet");
        exp_ord = '{0, 1, 2, 0, 1, 2};
        check("fair_count", 64'(grant_log.size() - log_base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (log_base + i < grant_log.size())
                check("fair_order", 64'(grant_log[log_base + i]), 64'(exp_ord[i]));
        end
        for (int i = 0; i < 3; i++) check("fair_done", 64'(done_cnt[i] - s_done[i]), 64'd2);

        // Doorbell coinciding with the grant decrement
        do_reset();
        snap();
        db(4'b0010, 1);
        db(4'b0010, 1);
        wait_quiet("simul_quiet");
        check("simul_submits", 64'(sub_cnt[1] - s_sub[1]), 64'd2);

        // Saturation behind an in-flight request
        do_reset();
        snap();
        comp_hold = 1'b1;
        db(4'b0001, 1);
        repeat (3) @(negedge clk);
        db(4'b1000, 17);
        check("sat_overflow", 64'(req_overflow[3]), 64'd1);
        comp_hold = 1'b0;
        wait_quiet("sat_quiet");
        check("sat_submits", 64'(sub_cnt[3] - s_sub[3]), 64'd15);
        check("sat_done", 64'(done_cnt[3] - s_done[3]), 64'd15);
        check("sat_sticky", 64'(req_overflow[3]), 64'd1);

        // Reset while waiting for completion
        do_reset();
        snap();
        comp_hold = 1'b1;
        db(4'b0100, 1);
        db(4'b0010, 1);
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy_after", 64'(busy), 64'd0);
        check("midrst_no_done", 64'(req_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        comp_hold = 1'b0;
        wait_quiet("midrst_quiet");
        check("midrst_no_resubmit", 64'(sub_cnt[1] + sub_cnt[2] - s_sub[1] - s_sub[2]), 64'd1);
        check("midrst_no_done2", 64'(done_cnt[2] - s_done[2]), 64'd0);
        check("midrst_ovf_clear", 64'(req_overflow), 64'd0);
        snap();
        db(4'b0001, 1);
        wait_quiet("midrst_fresh_quiet");
        check("midrst_fresh_done", 64'(done_cnt[0] - s_done[0]), 64'd1);

`ifdef CAI_ARB_TIMEOUT_EN
        // Watchdog abort, then the next pending requester is served
        do_reset();
        snap();
        comp_hold = 1'b1;
        db(4'b0011, 1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (cai_submit_doorbell) seen = 1'b1;
        end
        check("wd_first_submit", 64'(seen), 64'd1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (timeout) seen = 1'b1;
        end
        check("wd_timeout_seen", 64'(seen), 64'd1);
        check("wd_timeout_delay", 64'(n), 64'(TO + 1));
        check("wd_no_done", 64'(done_cnt[0] - s_done[0]), 64'd0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (cai_submit_doorbell) seen = 1'b1;
        end
        check("wd_next_submit", 64'(seen), 64'd1);
        check("wd_next_gid", 64'(grant_id), 64'd1);
        comp_hold = 1'b0;
        wait_quiet("wd_quiet");
        check("wd_next_done", 64'(done_cnt[1] - s_done[1]), 64'd1);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
